masked_sbox_out_collect: RTL and testbench

- Downstream neighbour of the final stage of the 3-cycle, 2-share masked AES S-box.
- Takes the two 8-bit output shares that the last stage produces every cycle and applies the output linear basis change share-wise. It adds the affine constant to share 0 only.
- Results are buffered in a small FIFO with a valid/ready interface, because the masked pipeline never stalls.
- Provides a credit signal (issue_ok) so the byte issuer never launches a byte that has no buffer slot.

---
 rtl/masked_sbox_out_collect_pkg.sv | 22 ++
 rtl/masked_share_fifo.sv | 52 +++++
 rtl/masked_sbox_out_collect.sv | 80 ++++++++
 tb/tb_masked_sbox_out_collect.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/masked_sbox_out_collect_pkg.sv
// Shared types and helpers for the masked S-box output collector.
// Holds the share width, default matrix/affine constants and the GF(2) mat-vec helper.
package masked_sbox_pkg;

  localparam int          SHARE_W      = 8;
  localparam logic [63:0] LIN_MAT_DEF  = 64'h0;
  localparam logic [7:0]  AFFINE_C_DEF = 8'h63;

  typedef struct packed {
    logic [SHARE_W-1:0] s0;
    logic [SHARE_W-1:0] s1;
  } share_pair_t;

  // Row k of mat is mat[8k+7:8k]; output bit k is the parity of row k AND vec.
  function automatic logic [7:0] gf2_matvec8(input logic [63:0] mat, input logic [7:0] vec);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k] = ^(mat[8*k +: 8] & vec);
    return r;
  endfunction

endpackage

// File: rtl/masked_share_fifo.sv
// Two-share FIFO: registered entries, wrapping pointers and an occupancy count.
// Outputs read straight from the head entry and are forced to zero when empty.
module masked_share_fifo
  import masked_sbox_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   ready,
  input  logic [SHARE_W-1:0]     push_s0,
  input  logic [SHARE_W-1:0]     push_s1,
  output logic                   out_valid,
  output logic                   full,
  output logic [SHARE_W-1:0]     out_s0,
  output logic [SHARE_W-1:0]     out_s1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  share_pair_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = out_valid & ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign out_s0    = out_valid ? mem[rd_ptr].s0 : '0;
  assign out_s1    = out_valid ? mem[rd_ptr].s1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= '{s0: push_s0, s1: push_s1};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/masked_sbox_out_collect.sv
// Output collector for the 2-share masked AES S-box: share-wise linear map, FIFO, credit.
// Optional MASKED_SBOX_OUT_REFRESH_EN adds a ran port that remasks both shares on push.
module masked_sbox_out_collect
  import masked_sbox_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          PIPE_LAT = 3,
  parameter logic [63:0] LIN_MAT  = LIN_MAT_DEF,
  parameter logic [7:0]  AFFINE_C = AFFINE_C_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue,
  output logic         issue_ok,
  input  logic [7:0]   in_s0,
  input  logic [7:0]   in_s1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_s0,
  output logic [7:0]   out_s1,
  output logic         overflow
`ifdef MASKED_SBOX_OUT_REFRESH_EN
  ,
  input  logic [7:0]   ran
`endif
);

  logic [PIPE_LAT-1:0]   vld_pipe;
  logic                  arrive, pop, fifo_full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0]            t0, t1, w0, w1;
  int                    inflight;

  assign arrive = vld_pipe[PIPE_LAT-1];
  assign pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= (vld_pipe << 1) | PIPE_LAT'(issue);
  end

  // Credit ignores a pop happening this cycle; it shows up through count next cycle.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < PIPE_LAT; i++) inflight += int'(vld_pipe[i]);
    issue_ok = (int'(fifo_count) + inflight) < DEPTH;
  end

  // Each share goes through its own matrix instance; no gate mixes the two shares.
  assign t0 = gf2_matvec8(LIN_MAT, in_s0) ^ AFFINE_C;
  assign t1 = gf2_matvec8(LIN_MAT, in_s1);

`ifdef MASKED_SBOX_OUT_REFRESH_EN
  assign w0 = t0 ^ ran;
  assign w1 = t1 ^ ran;
`else
  assign w0 = t0;
  assign w1 = t1;
`endif

  masked_share_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (arrive),
    .ready     (out_ready),
    .push_s0   (w0),
    .push_s1   (w1),
    .out_valid (out_valid),
    .full      (fifo_full),
    .out_s0    (out_s0),
    .out_s1    (out_s1),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             overflow <= 1'b0;
    else if (arrive & fifo_full & ~pop)  overflow <= 1'b1;
  end

endmodule

// File: tb/tb_masked_sbox_out_collect.sv
// Directed bench for masked_sbox_out_collect with a queue-level reference model.
// Works with or without MASKED_SBOX_OUT_REFRESH_EN (only unmasked values are compared then).
module tb_masked_sbox_out_collect;

  localparam int          DEPTH = 4;
  localparam logic [63:0] MAT   = 64'h8040201008040201;
  localparam logic [7:0]  AFF   = 8'h63;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] iss_s0 = '0, iss_s1 = '0;
  logic [7:0] in_s0, in_s1, out_s0, out_s1;
  logic       issue_ok, out_valid, overflow;
  logic [15:0] up0, up1, up2;
`ifdef MASKED_SBOX_OUT_REFRESH_EN
  logic [7:0] ran = '0;
  always @(posedge clk) ran <= 8'($urandom);
`endif

  always #5 clk = ~clk;

  masked_sbox_out_collect #(.DEPTH(DEPTH), .PIPE_LAT(3), .LIN_MAT(MAT), .AFFINE_C(AFF)) dut (
    .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
    .in_s0(in_s0), .in_s1(in_s1), .out_valid(out_valid), .out_ready(out_ready),
    .out_s0(out_s0), .out_s1(out_s1), .overflow(overflow)
`ifdef MASKED_SBOX_OUT_REFRESH_EN
    , .ran(ran)
`endif
  );

  // Stand-in for the 3-stage S-box: never reset, carries junk when nothing was issued.
  always @(posedge clk) begin
    up0 <= issue ? {iss_s0, iss_s1} : 16'($urandom);
    up1 <= up0;
    up2 <= up1;
  end
  assign in_s0 = up2[15:8];
  assign in_s1 = up2[7:0];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Matrix product as a sum of the columns selected by the set input bits.
  function automatic logic [7:0] lin_ref(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++)
      if (x[j]) for (int k = 0; k < 8; k++) r[k] = r[k] ^ MAT[8*k+j];
    return r;
  endfunction

  typedef struct { int arr; logic [7:0] s0; logic [7:0] s1; } pend_t;
  pend_t      pend[$];
  logic [15:0] mq[$];
  logic       m_ovf = 1'b0;
  int         cyc = 0, m_sz;
  bit         m_pop;

  // Reference: bytes arrive 3 cycles after issue, then sit in a bounded queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      mq.delete();
      m_ovf = 1'b0;
      cyc   = 0;
    end else begin
      m_sz  = mq.size();
      m_pop = (m_sz > 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].arr == cyc) begin
        if (m_sz < DEPTH || m_pop) mq.push_back({lin_ref(pend[0].s0) ^ AFF, lin_ref(pend[0].s1)});
        else m_ovf = 1'b1;
        void'(pend.pop_front());
      end
      if (issue) pend.push_back('{cyc + 3, iss_s0, iss_s1});
      cyc++;
    end
  end

  logic [15:0] head;
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        head = mq[0];
`ifdef MASKED_SBOX_OUT_REFRESH_EN
        chk("unmasked", 32'(out_s0 ^ out_s1), 32'(head[15:8] ^ head[7:0]));
`else
        chk("out_s0", 32'(out_s0), 32'(head[15:8]));
        chk("out_s1", 32'(out_s1), 32'(head[7:0]));
`endif
      end else begin
        chk("empty_s0", 32'(out_s0), 32'h0);
        chk("empty_s1", 32'(out_s1), 32'h0);
      end
      chk("issue_ok", 32'(issue_ok), 32'((mq.size() + pend.size()) < DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  bit cnt_en = 1'b0;
  int npop = 0;
  always @(negedge clk) if (cnt_en && out_valid && out_ready) npop++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    issue  = 1'b1;
    iss_s0 = a;
    iss_s1 = b;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_s0", 32'(out_s0), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_issue_ok", 32'(issue_ok), 32'h1);

    // Identity matrix: A5 ^ 63 = C6 on share 0, share 1 passes through.
    drive(8'hA5, 8'h3C);
    step(); issue = 1'b0;
    step(); step();
    @(negedge clk);
    chk("id_early", 32'(out_valid), 32'h0);
    step();
    @(negedge clk);
    chk("id_valid", 32'(out_valid), 32'h1);
`ifdef MASKED_SBOX_OUT_REFRESH_EN
    chk("id_xor", 32'(out_s0 ^ out_s1), 32'hFA);
`else
    chk("id_s0", 32'(out_s0), 32'hC6);
    chk("id_s1", 32'(out_s1), 32'h3C);
`endif
    out_ready = 1'b1;
    step(); step();

    // Streaming: 16 back-to-back bytes must leave on 16 consecutive cycles.
    for (int i = 0; i < 16; i++) begin
      drive(8'($urandom), 8'($urandom));
      if (i == 4) cnt_en = 1'b1;
      step();
    end
    issue = 1'b0;
    repeat (4) step();
    cnt_en = 1'b0;
    chk("stream_pops", 32'(npop), 32'd16);
    repeat (2) step();

    // Credit exhaustion with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("credit_pre", 32'(issue_ok), 32'h1);
      drive(8'(8'h40 + i), 8'(8'h50 + i));
      step();
    end
    issue = 1'b0;
    chk("credit_drop", 32'(issue_ok), 32'h0);
    repeat (4) step();
    chk("credit_full", 32'(issue_ok), 32'h0);
    chk("credit_noovf", 32'(overflow), 32'h0);
    out_ready = 1'b1;
    chk("credit_pop_cycle", 32'(issue_ok), 32'h0);
    step();
    chk("credit_back", 32'(issue_ok), 32'h1);
    repeat (5) step();

    // Fill to 3, then 10 cycles of simultaneous push and pop (wraps the pointers).
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 6) out_ready = 1'b1;
      drive(8'($urandom), 8'($urandom));
      step();
    end
    issue = 1'b0;
    repeat (6) step();

    // Overflow: fifth byte issued against a full FIFO is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("ovf_no_credit", 32'(issue_ok), 32'h0);
      drive(8'(8'h10 + i), 8'(8'h20 + i));
      step();
    end
    issue = 1'b0;
    repeat (3) step();
    chk("ovf_set", 32'(overflow), 32'h1);
`ifdef MASKED_SBOX_OUT_REFRESH_EN
    chk("ovf_head", 32'(out_s0 ^ out_s1), 32'h53);
`else
    chk("ovf_head_s0", 32'(out_s0), 32'h73);
    chk("ovf_head_s1", 32'(out_s1), 32'h20);
`endif
    repeat (3) step();
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Reset between edges with 2 buffered and 2 in flight.
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    drive(8'hE1, 8'h1E); step();
    drive(8'hE2, 8'h2E); step();
    issue = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ovf", 32'(overflow), 32'h0);
    chk("mid_rst_issue_ok", 32'(issue_ok), 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    chk("post_rst_empty", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
